// File: rtl/fifo_rd_drainer_if.sv
// Read-domain bundle between an async FIFO, the drainer and its downstream stream sink.
// The master modport is the drainer's view; slave is the FIFO/sink environment's view.
interface fifo_rd_drainer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   en;
    logic                   empty;
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   r_en;
    logic                   m_valid;
    logic                   m_ready;
    logic [DATA_WIDTH-1:0]  m_data;
    logic [COUNT_WIDTH-1:0] rd_count;

    modport master (
        input  en,
        input  empty,
        input  fifo_rdata,
        input  m_ready,
        output r_en,
        output m_valid,
        output m_data,
        output rd_count
    );

    modport slave (
        output en,
        output empty,
        output fifo_rdata,
        output m_ready,
        input  r_en,
        input  m_valid,
        input  m_data,
        input  rd_count
    );
endinterface

// File: rtl/fifo_rd_drainer.sv
// Async-FIFO read-side drainer: issues r_en, absorbs the 1-cycle read latency and
// re-presents words on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_drainer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    fifo_rd_drainer_if.master bus
);

    logic                   pending_q, pending_d;
    logic [1:0]             occ_q, occ_d;
    logic [DATA_WIDTH-1:0]  skid_q [2];
    logic [DATA_WIDTH-1:0]  skid_d [2];
    logic [COUNT_WIDTH-1:0] rdCount_q, rdCount_d;

    logic       pop;
    logic       push;
    logic       hasSpace;
    logic       rEn;
    logic [1:0] wrSlot;

    // A read is only issued when the buffer can take it counting the word in flight.
    always_comb begin
        pop       = (occ_q != 2'd0) & bus.m_ready;
        push      = pending_q;
        hasSpace  = ({1'b0, occ_q} + {2'b00, pending_q}) < (3'd2 + {2'b00, pop});
        rEn       = rrst_n & bus.en & ~bus.empty & hasSpace;
        wrSlot    = occ_q - {1'b0, pop};

        pending_d = rEn;
        occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
        rdCount_d = rdCount_q + COUNT_WIDTH'(pop);

        skid_d    = skid_q;
        if (pop) begin
            skid_d[0] = skid_q[1];
        end
        if (push) begin
            skid_d[wrSlot[0]] = bus.fifo_rdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            pending_q <= 1'b0;
            occ_q     <= 2'd0;
            rdCount_q <= '0;
        end else begin
            pending_q <= pending_d;
            occ_q     <= occ_d;
            rdCount_q <= rdCount_d;
        end
    end

    // Storage needs no reset: its contents are ignored while occupancy is zero.
    always_ff @(posedge rclk) begin
        skid_q <= skid_d;
    end

    assign bus.r_en     = rEn;
    assign bus.m_valid  = (occ_q != 2'd0);
    assign bus.m_data   = skid_q[0];
    assign bus.rd_count = rdCount_q;

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Directed bench for fifo_rd_drainer: a small registered-read FIFO model feeds the
// main instance, a second instance with a 4-bit counter exercises wrap-around.
module tb_fifo_rd_drainer;

    logic rclk;
    logic rrst_n;

    fifo_rd_drainer_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) bus  ();
    fifo_rd_drainer_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4))  bus4 ();

    fifo_rd_drainer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    fifo_rd_drainer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus4)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    int         rdPtr = 0;
    int         wrPtr = 0;
    logic       flushReq = 1'b0;
    logic       gateEmpty = 1'b0;
    logic [7:0] fifoRdata = 8'h00;

    logic [7:0] delivered [0:255];
    int         nDel = 0;
    int         nRen = 0;
    int         viol = 0;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign bus.empty      = gateEmpty || (rdPtr == wrPtr);
    assign bus.fifo_rdata = fifoRdata;

    // FIFO model: data_out is registered, valid the cycle after an accepted r_en.
    always @(posedge rclk) begin
        if (flushReq) begin
            rdPtr <= wrPtr;
        end else if (bus.r_en) begin
            fifoRdata <= mem[rdPtr];
            rdPtr     <= rdPtr + 1;
        end
    end

    // Stream log plus protocol watch on r_en.
    always @(posedge rclk) begin
        if (bus.r_en && (bus.empty || !rrst_n)) viol <= viol + 1;
        if (rrst_n && bus.r_en) nRen <= nRen + 1;
        if (rrst_n && bus.m_valid && bus.m_ready) begin
            delivered[nDel] <= bus.m_data;
            nDel            <= nDel + 1;
        end
    end

    task automatic pushWord(input logic [7:0] v);
        mem[wrPtr] = v;
        wrPtr      = wrPtr + 1;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic doReset();
        rrst_n       = 1'b0;
        flushReq     = 1'b1;
        gateEmpty    = 1'b0;
        bus.en       = 1'b0;
        bus.m_ready  = 1'b0;
        bus4.en      = 1'b0;
        bus4.m_ready = 1'b0;
        repeat (2) tick();
        flushReq = 1'b0;
        rrst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        tick();
        pushWord(8'hE0);
        pushWord(8'hE1);
        bus.en      = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.r_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.rd_count !== 16'd0 ||
                bus4.rd_count !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold c=%0d got r_en=%b m_valid=%b rd_count=%0d cnt4=%0d want 0 0 0 0",
                         c, bus.r_en, bus.m_valid, bus.rd_count, bus4.rd_count);
            end
            tick();
        end
        rrst_n = 1'b1;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.rd_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_release got m_valid=%b rd_count=%0d want 0 0",
                     bus.m_valid, bus.rd_count);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] expData [0:6];
        logic       expRen  [0:6];
        logic       expVal  [0:6];
        int         baseDel;
        expRen  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        expVal  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        expData = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        doReset();
        baseDel = nDel;
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        bus.en      = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++;
            if (bus.r_en !== expRen[c] || bus.m_valid !== expVal[c] ||
                (expVal[c] && bus.m_data !== expData[c])) begin
                errors++;
                $display("[TB] FAIL stream c=%0d got r_en=%b m_valid=%b m_data=%h want %b %b %h",
                         c, bus.r_en, bus.m_valid, bus.m_data, expRen[c], expVal[c], expData[c]);
            end
            @(posedge rclk);
        end
        #1;
        checks++;
        if (bus.rd_count !== 16'd3 || (nDel - baseDel) != 3) begin
            errors++;
            $display("[TB] FAIL stream_count got rd_count=%0d delivered=%0d want 3 3",
                     bus.rd_count, nDel - baseDel);
        end
    endtask

    task automatic test_back_pressure();
        int baseRen;
        int baseDel;
        doReset();
        baseRen = nRen;
        baseDel = nDel;
        for (int i = 0; i < 5; i++) pushWord(8'hA0 + 8'(i));
        bus.en      = 1'b1;
        bus.m_ready = 1'b0;
        repeat (6) tick();
        checks++;
        if ((nRen - baseRen) != 2 || dut.occ_q !== 2'd2 || bus.m_valid !== 1'b1 ||
            bus.m_data !== 8'hA0) begin
            errors++;
            $display("[TB] FAIL bp_hold got pulses=%0d occ=%0d m_valid=%b m_data=%h want 2 2 1 a0",
                     nRen - baseRen, dut.occ_q, bus.m_valid, bus.m_data);
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== (8'hA0 + 8'(i))) begin
                errors++;
                $display("[TB] FAIL bp_drain i=%0d got m_valid=%b m_data=%h want 1 %h",
                         i, bus.m_valid, bus.m_data, 8'hA0 + 8'(i));
            end
            tick();
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || (nDel - baseDel) != 5 || bus.rd_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL bp_done got m_valid=%b delivered=%0d rd_count=%0d want 0 5 5",
                     bus.m_valid, nDel - baseDel, bus.rd_count);
        end
    endtask

    task automatic test_empty_gating();
        int baseDel;
        int baseViol;
        doReset();
        baseDel  = nDel;
        baseViol = viol;
        for (int i = 0; i < 4; i++) pushWord(8'hB0 + 8'(i));
        bus.en      = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            gateEmpty = (c % 2 == 0);
            #1;
            checks++;
            if (bus.empty && bus.r_en) begin
                errors++;
                $display("[TB] FAIL gate_ren c=%0d got r_en=%b empty=%b want r_en 0",
                         c, bus.r_en, bus.empty);
            end
            @(posedge rclk);
            #1;
        end
        gateEmpty = 1'b0;
        repeat (4) tick();
        checks++;
        if ((nDel - baseDel) != 4 || rdPtr != wrPtr || (viol - baseViol) != 0) begin
            errors++;
            $display("[TB] FAIL gate_total got delivered=%0d left=%0d viol=%0d want 4 0 0",
                     nDel - baseDel, wrPtr - rdPtr, viol - baseViol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (delivered[baseDel + i] !== (8'hB0 + 8'(i))) begin
                errors++;
                $display("[TB] FAIL gate_order i=%0d got %h want %h",
                         i, delivered[baseDel + i], 8'hB0 + 8'(i));
            end
        end
    endtask

    task automatic test_en_drop();
        int baseDel;
        doReset();
        baseDel = nDel;
        for (int i = 0; i < 4; i++) pushWord(8'hC0 + 8'(i));
        bus.en      = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.r_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL endrop_first got r_en=%b want 1", bus.r_en);
        end
        tick();
        bus.en = 1'b0;
        for (int c = 1; c < 7; c++) begin
            #1;
            checks++;
            if (bus.r_en !== 1'b0 || bus.m_valid !== (c == 2) ||
                (c == 2 && bus.m_data !== 8'hC0)) begin
                errors++;
                $display("[TB] FAIL endrop c=%0d got r_en=%b m_valid=%b m_data=%h want 0 %b c0",
                         c, bus.r_en, bus.m_valid, bus.m_data, (c == 2));
            end
            @(posedge rclk);
        end
        #1;
        checks++;
        if ((nDel - baseDel) != 1 || delivered[baseDel] !== 8'hC0) begin
            errors++;
            $display("[TB] FAIL endrop_total got delivered=%0d first=%h want 1 c0",
                     nDel - baseDel, delivered[baseDel]);
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] expCount;
        doReset();
        bus4.en      = 1'b1;
        bus4.empty   = 1'b0;
        bus4.m_ready = 1'b0;
        repeat (4) tick();
        for (int k = 1; k <= 17; k++) begin
            checks++;
            if (bus4.m_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_valid k=%0d got m_valid=%b want 1", k, bus4.m_valid);
            end
            bus4.m_ready = 1'b1;
            tick();
            bus4.m_ready = 1'b0;
            expCount = 4'(k % 16);
            checks++;
            if (bus4.rd_count !== expCount) begin
                errors++;
                $display("[TB] FAIL wrap_count k=%0d got %0d want %0d", k, bus4.rd_count, expCount);
            end
        end
        bus4.en    = 1'b0;
        bus4.empty = 1'b1;
    endtask

    initial begin
        rrst_n          = 1'b0;
        bus.en          = 1'b0;
        bus.m_ready     = 1'b0;
        bus4.en         = 1'b0;
        bus4.empty      = 1'b1;
        bus4.m_ready    = 1'b0;
        bus4.fifo_rdata = 8'h5A;

        test_reset();
        test_streaming();
        test_back_pressure();
        test_empty_gating();
        test_en_drop();
        test_counter_wrap();

        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL ren_protocol got %0d illegal r_en cycles want 0", viol);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
